// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer at the commit stage of the RV32I pipeline.
// Supplies the old CSR value for rd, applies CSR ops, and sequences ECALL/illegal/MRET redirects.
module csr_trap_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Valid_W,
  input  logic [31:0] Instr_W,
  input  logic [31:0] PC_W,
  input  logic [31:0] CSR_Src_W,
  input  logic        CSRWrite_W,
  input  logic        Is_ECALL_W,
  input  logic        Is_MRET_W,
  input  logic        Illegal_Instr_W,
  output logic [31:0] CSR_RData,
  output logic        Trap_Redirect,
  output logic [31:0] Redirect_PC
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [11:0] csr_addr;
  logic [2:0]  funct3;
  assign csr_addr = Instr_W[31:20];
  assign funct3   = Instr_W[14:12];

  logic        mie, mpie;
  logic [31:0] mtvec, mscratch, mepc, mcause, mtval;
  logic [63:0] mcycle, minstret;

  logic [31:0] rdata_raw, wdata;
  logic        csr_impl;

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    rdata_raw = 32'h0;
    csr_impl  = 1'b1;
    case (csr_addr)
      12'h300: rdata_raw = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
      12'h301: rdata_raw = MISA_VALUE;
      12'h305: rdata_raw = mtvec;
      12'h340: rdata_raw = mscratch;
      12'h341: rdata_raw = mepc;
      12'h342: rdata_raw = mcause;
      12'h343: rdata_raw = mtval;
      12'hB00, 12'hC00: rdata_raw = mcycle[31:0];
      12'hB80, 12'hC80: rdata_raw = mcycle[63:32];
      12'hB02, 12'hC02: rdata_raw = minstret[31:0];
      12'hB82, 12'hC82: rdata_raw = minstret[63:32];
      12'hF14: rdata_raw = HART_ID;
      default: csr_impl = 1'b0;
    endcase
  end

  logic csr_access, csr_illegal, take_illegal, take_ecall, take_trap, take_mret;
  logic csr_we, retire;

  assign csr_access   = Valid_W && (funct3 != 3'b000);
  // Any write-intent to the 0xC00..0xFFF read-only space is illegal, even if the value would not change.
  assign csr_illegal  = csr_access && (!csr_impl || ((csr_addr[11:10] == 2'b11) && CSRWrite_W));
  assign take_illegal = Valid_W && (Illegal_Instr_W || csr_illegal);
  assign take_ecall   = Valid_W && Is_ECALL_W && !take_illegal;
  assign take_trap    = take_illegal || take_ecall;
  assign take_mret    = Valid_W && Is_MRET_W && !take_trap;
  assign csr_we       = csr_access && CSRWrite_W && !take_trap;
  assign retire       = Valid_W && !take_trap;

  always_comb begin
    case (funct3[1:0])
      2'b01:   wdata = CSR_Src_W;
      2'b10:   wdata = rdata_raw | CSR_Src_W;
      2'b11:   wdata = rdata_raw & ~CSR_Src_W;
      default: wdata = rdata_raw;
    endcase
  end

  assign CSR_RData     = rst ? 32'h0 : rdata_raw;
  assign Trap_Redirect = !rst && (take_trap || take_mret);
  always_comb begin
    Redirect_PC = 32'h0;
    if (!rst) begin
      if (take_trap)      Redirect_PC = mtvec;
      else if (take_mret) Redirect_PC = mepc;
    end
  end

  // A written counter half replaces its increment; the other half keeps the pre-write +1 value.
  logic [63:0] mcycle_next, minstret_next;
  logic        instret_wr;

  always_comb begin
    mcycle_next = mcycle + 64'd1;
    if (csr_we && csr_addr == 12'hB00) mcycle_next[31:0]  = wdata;
    if (csr_we && csr_addr == 12'hB80) mcycle_next[63:32] = wdata;

    instret_wr    = csr_we && (csr_addr == 12'hB02 || csr_addr == 12'hB82);
    minstret_next = minstret + {63'b0, retire && !instret_wr};
    if (csr_we && csr_addr == 12'hB02) minstret_next[31:0]  = wdata;
    if (csr_we && csr_addr == 12'hB82) minstret_next[63:32] = wdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= MTVEC_RESET & ALIGN_MASK;
      mscratch <= 32'h0;
      mepc     <= 32'h0;
      mcause   <= 32'h0;
      mtval    <= 32'h0;
      mcycle   <= 64'h0;
      minstret <= 64'h0;
    end else begin
      mcycle   <= mcycle_next;
      minstret <= minstret_next;
      if (take_trap) begin
        mepc   <= PC_W & ALIGN_MASK;
        mcause <= take_illegal ? 32'd2 : 32'd11;
        mtval  <= take_illegal ? Instr_W : 32'h0;
        mpie   <= mie;
        mie    <= 1'b0;
      end else begin
        if (take_mret) begin
          mie  <= mpie;
          mpie <= 1'b1;
        end
        if (csr_we) begin
          case (csr_addr)
            12'h300: begin
              mie  <= wdata[3];
              mpie <= wdata[7];
            end
            12'h305: mtvec    <= wdata & ALIGN_MASK;
            12'h340: mscratch <= wdata;
            12'h341: mepc     <= wdata & ALIGN_MASK;
            12'h342: mcause   <= wdata;
            12'h343: mtval    <= wdata;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: a driver pushes model predictions, a monitor pops and compares.
module tb_csr_trap_unit;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Valid_W = 1'b0;
  logic [31:0] Instr_W = 32'h0;
  logic [31:0] PC_W = 32'h0;
  logic [31:0] CSR_Src_W = 32'h0;
  logic        CSRWrite_W = 1'b0;
  logic        Is_ECALL_W = 1'b0;
  logic        Is_MRET_W = 1'b0;
  logic        Illegal_Instr_W = 1'b0;
  logic [31:0] CSR_RData;
  logic        Trap_Redirect;
  logic [31:0] Redirect_PC;

  csr_trap_unit #(.MTVEC_RESET(MTVEC_RST)) dut (
    .clk(clk), .rst(rst), .Valid_W(Valid_W), .Instr_W(Instr_W), .PC_W(PC_W),
    .CSR_Src_W(CSR_Src_W), .CSRWrite_W(CSRWrite_W), .Is_ECALL_W(Is_ECALL_W),
    .Is_MRET_W(Is_MRET_W), .Illegal_Instr_W(Illegal_Instr_W),
    .CSR_RData(CSR_RData), .Trap_Redirect(Trap_Redirect), .Redirect_PC(Redirect_PC)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: architectural CSR state kept as plain variables.
  logic        m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle, m_instret;

  function automatic void model_reset();
    m_mie = 0; m_mpie = 0;
    m_mtvec = MTVEC_RST & ~32'h3;
    m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_cycle = 0; m_instret = 0;
  endfunction

  function automatic logic model_read(input logic [11:0] a, output logic [31:0] v);
    logic ok = 1'b1;
    v = 32'h0;
    case (a)
      12'h300: v = 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
      12'h301: v = 32'h4000_0100;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'hB00, 12'hC00: v = m_cycle[31:0];
      12'hB80, 12'hC80: v = m_cycle[63:32];
      12'hB02, 12'hC02: v = m_instret[31:0];
      12'hB82, 12'hC82: v = m_instret[63:32];
      12'hF14: v = 32'h0;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Drive one cycle of stimulus, predict its outputs, then advance the model across the edge.
  task automatic drive(input logic v, input logic [11:0] a, input logic [2:0] f3,
                       input logic [4:0] rs1, input logic [31:0] pc, input logic [31:0] src,
                       input logic wr, input logic ec, input logic mr, input logic il,
                       input string nm);
    exp_t e;
    logic [31:0] instr, old, nv;
    logic impl, illegal, ecall, mret, trap, we, ins_wr;
    logic [63:0] cyc, ins;
    instr = {a, rs1, f3, 5'd0, 7'h73};
    Valid_W = v; Instr_W = instr; PC_W = pc; CSR_Src_W = src;
    CSRWrite_W = wr; Is_ECALL_W = ec; Is_MRET_W = mr; Illegal_Instr_W = il;

    impl    = model_read(a, old);
    illegal = v && (il || (f3 != 0 && (!impl || (a >= 12'hC00 && wr))));
    ecall   = v && ec && !illegal;
    trap    = illegal || ecall;
    mret    = v && mr && !trap;
    e.name = nm;
    e.rdata = old;
    e.redirect = trap || mret;
    e.pc = trap ? m_mtvec : (mret ? m_mepc : 32'h0);
    sb_q.push_back(e);

    we = v && wr && f3 != 0 && !trap;
    case (f3[1:0])
      2'd1: nv = src;
      2'd2: nv = old | src;
      2'd3: nv = old & ~src;
      default: nv = old;
    endcase
    cyc = m_cycle + 1;
    if (we && a == 12'hB00) cyc[31:0] = nv;
    if (we && a == 12'hB80) cyc[63:32] = nv;
    ins_wr = we && (a == 12'hB02 || a == 12'hB82);
    ins = m_instret + ((v && !trap && !ins_wr) ? 64'd1 : 64'd0);
    if (we && a == 12'hB02) ins[31:0] = nv;
    if (we && a == 12'hB82) ins[63:32] = nv;
    m_cycle = cyc;
    m_instret = ins;
    if (trap) begin
      m_mepc = pc & ~32'h3;
      m_mcause = illegal ? 32'd2 : 32'd11;
      m_mtval = illegal ? instr : 32'h0;
      m_mpie = m_mie;
      m_mie = 0;
    end else begin
      if (mret) begin
        m_mie = m_mpie;
        m_mpie = 1;
      end
      if (we) begin
        case (a)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h305: m_mtvec = nv & ~32'h3;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc = nv & ~32'h3;
          12'h342: m_mcause = nv;
          12'h343: m_mtval = nv;
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input string nm);
    drive(1, a, 3'd2, 5'd0, 32'h0, 32'h0, 0, 0, 0, 0, nm);
  endtask

  // Monitor: compares the DUT's combinational response mid-cycle, away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.name, "_rdata"}, CSR_RData, e.rdata);
        check({e.name, "_redir"}, {31'b0, Trap_Redirect}, {31'b0, e.redirect});
        check({e.name, "_rpc"}, Redirect_PC, e.pc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [11:0] pool [19] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                             12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                             12'hC82, 12'hF14, 12'h344, 12'h7C0, 12'hB03};

  initial begin
    model_reset();
    // Outputs held at zero throughout reset, even with a trap request present.
    Valid_W = 1; Is_ECALL_W = 1; Instr_W = 32'h3000_2073;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rdata", CSR_RData, 32'h0);
    check("reset_redir", {31'b0, Trap_Redirect}, 32'h0);
    check("reset_rpc", Redirect_PC, 32'h0);
    @(posedge clk);
    #1;
    rst = 0;

    rd(12'hB00, "mcycle_at_release");
    rd(12'hB00, "mcycle_plus1");
    rd(12'h300, "mstatus_reset");
    rd(12'h305, "mtvec_reset");
    rd(12'h301, "misa");

    drive(1, 12'h340, 3'd1, 5'd5, 32'h40, 32'hDEAD_BEEF, 1, 0, 0, 0, "csrrw_mscratch");
    drive(1, 12'h340, 3'd2, 5'd6, 32'h44, 32'h0000_00F0, 1, 0, 0, 0, "csrrs_mscratch");
    drive(1, 12'h340, 3'd3, 5'd7, 32'h48, 32'hFFFF_0000, 1, 0, 0, 0, "csrrc_mscratch");
    rd(12'h340, "mscratch_final");

    drive(1, 12'hC00, 3'd1, 5'd1, 32'h0000_0300, 32'h1234_5678, 1, 0, 0, 0, "csrrw_cycle_ro");
    rd(12'h342, "mcause_illegal");
    rd(12'h343, "mtval_illegal");
    rd(12'hC00, "cycle_unmodified");

    drive(1, 12'h300, 3'd6, 5'd8, 32'h60, 32'h8, 1, 0, 0, 0, "csrrsi_mie");
    rd(12'hB02, "minstret_pre_ecall");
    drive(1, 12'h000, 3'd0, 5'd0, 32'h0000_0204, 32'h0, 0, 1, 0, 0, "ecall");
    rd(12'hB02, "minstret_post_ecall");
    rd(12'h341, "mepc_ecall");
    rd(12'h342, "mcause_ecall");
    rd(12'h343, "mtval_ecall");
    rd(12'h300, "mstatus_ecall");
    drive(0, 12'h000, 3'd0, 5'd0, 32'h88, 32'h0, 0, 1, 0, 0, "bubble_ecall");
    drive(1, 12'h302, 3'd0, 5'd0, 32'h0000_0500, 32'h0, 0, 0, 1, 0, "mret");
    rd(12'h300, "mstatus_mret");
    rd(12'hB02, "minstret_mret");

    drive(1, 12'hB00, 3'd1, 5'd9, 32'h70, 32'hFFFF_FFFF, 1, 0, 0, 0, "wr_mcycle_max");
    drive(0, 12'hB80, 3'd2, 5'd0, 32'h0, 32'h0, 0, 0, 0, 0, "idle_mcycleh");
    rd(12'hB80, "mcycleh_carry");
    rd(12'hB00, "mcycle_wrapped");
    drive(1, 12'hB80, 3'd1, 5'd10, 32'h74, 32'h0000_0055, 1, 0, 0, 0, "wr_mcycleh");
    rd(12'hB80, "mcycleh_written");
    rd(12'hB00, "mcycle_counting");
    drive(1, 12'hB02, 3'd1, 5'd11, 32'h78, 32'h0000_1000, 1, 0, 0, 0, "wr_minstret");
    rd(12'hB02, "minstret_written");

    for (int i = 0; i < 400; i++) begin
      logic v, ec, mr, il, wr;
      logic [2:0] f3;
      logic [4:0] rs1;
      logic [31:0] src, pc;
      logic [11:0] a;
      v   = ($urandom_range(0, 7) != 0);
      ec  = ($urandom_range(0, 15) == 0);
      mr  = !ec && ($urandom_range(0, 15) == 0);
      il  = ($urandom_range(0, 31) == 0);
      a   = pool[$urandom_range(0, 18)];
      pc  = $urandom;
      rs1 = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      f3  = (ec || mr) ? 3'd0 : 3'($urandom_range(0, 7));
      src = f3[2] ? {27'b0, rs1} : $urandom;
      if (f3 == 3'd0)                    wr = 0;
      else if (f3[1:0] == 2'b01)         wr = 1;
      else                               wr = (rs1 != 0);
      drive(v, a, f3, rs1, pc, src, wr, ec, mr, il, $sformatf("rand%0d", i));
    end

    check("queue_drained", sb_q.size(), 32'd0);

    // A trap in flight is dropped the instant reset asserts.
    Valid_W = 1; Is_ECALL_W = 1; Is_MRET_W = 0; Illegal_Instr_W = 0; CSRWrite_W = 0;
    Instr_W = 32'h0000_0073;
    #1;
    check("pre_reset_redir", {31'b0, Trap_Redirect}, 32'h1);
    check("pre_reset_rpc", Redirect_PC, m_mtvec);
    rst = 1;
    #1;
    check("midreset_redir", {31'b0, Trap_Redirect}, 32'h0);
    check("midreset_rpc", Redirect_PC, 32'h0);
    check("midreset_rdata", CSR_RData, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
